// File: rtl/me_pkg.sv
// Shared constants, FSM encoding and saturating-subtract helper for the motion-estimation SAD search.
package me_pkg;

  localparam int TB_LENGTH = 8;
  localparam int SW_LENGTH = 32;
  localparam int SAD_W     = 14;
  localparam int MV_W      = 5;
  localparam int R         = SW_LENGTH - TB_LENGTH + 1;
  localparam int C         = (R - 1) / 2;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SEARCH = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  localparam logic [SAD_W-1:0] SAD_MAX = 14'h3FFF;

  function automatic logic [SAD_W-1:0] sat_sub(input logic [SAD_W-1:0] a,
                                               input logic [SAD_W-1:0] b);
    if (a > b) begin
      sat_sub = a - b;
    end else begin
      sat_sub = {SAD_W{1'b0}};
    end
  endfunction

endpackage

// File: rtl/sad_cmp.sv
// Candidate bias, strict less-than compare and best-candidate registers.
// ME_ZERO_BIAS_EN credits the centre (zero-MV) candidate with ZERO_BIAS.
module sad_cmp
  import me_pkg::*;
#(
  parameter int POS_W = 5,
  parameter int CTR   = 12
`ifdef ME_ZERO_BIAS_EN
  ,
  parameter int ZERO_BIAS = 16
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             init,
  input  logic             en,
  input  logic [SAD_W-1:0] sad,
  input  logic [POS_W-1:0] pos_x,
  input  logic [POS_W-1:0] pos_y,
  output logic [SAD_W-1:0] best_sad,
  output logic [POS_W-1:0] best_x,
  output logic [POS_W-1:0] best_y,
  output logic [SAD_W-1:0] nxt_best_sad,
  output logic [POS_W-1:0] nxt_best_x,
  output logic [POS_W-1:0] nxt_best_y
);

  logic [SAD_W-1:0] cand_s;
  logic [SAD_W-1:0] best_sad_r;
  logic [POS_W-1:0] best_x_r;
  logic [POS_W-1:0] best_y_r;

  // candidate value seen by the comparator
  always_comb begin
    cand_s = sad;
`ifdef ME_ZERO_BIAS_EN
    if ((pos_x == POS_W'(CTR)) && (pos_y == POS_W'(CTR))) begin
      cand_s = sat_sub(sad, SAD_W'(ZERO_BIAS));
    end else begin
      cand_s = sad;
    end
`endif
  end

  // next best values; strict less-than keeps the earlier candidate on ties
  always_comb begin
    nxt_best_sad = best_sad_r;
    nxt_best_x   = best_x_r;
    nxt_best_y   = best_y_r;
    if (en && (cand_s < best_sad_r)) begin
      nxt_best_sad = cand_s;
      nxt_best_x   = pos_x;
      nxt_best_y   = pos_y;
    end else begin
      nxt_best_sad = best_sad_r;
      nxt_best_x   = best_x_r;
      nxt_best_y   = best_y_r;
    end
  end

  // best-candidate registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      best_sad_r <= SAD_MAX;
      best_x_r   <= {POS_W{1'b0}};
      best_y_r   <= {POS_W{1'b0}};
    end else if (init) begin
      best_sad_r <= SAD_MAX;
      best_x_r   <= {POS_W{1'b0}};
      best_y_r   <= {POS_W{1'b0}};
    end else begin
      best_sad_r <= nxt_best_sad;
      best_x_r   <= nxt_best_x;
      best_y_r   <= nxt_best_y;
    end
  end

  assign best_sad = best_sad_r;
  assign best_x   = best_x_r;
  assign best_y   = best_y_r;

endmodule

// File: rtl/min_sad_search.sv
// Full-search minimum-SAD tracker: raster position counters, IDLE/SEARCH/DONE FSM and result registers.
// Optional zero-MV bias selected by ME_ZERO_BIAS_EN (handled inside sad_cmp).
module min_sad_search
  import me_pkg::*;
#(
  parameter int TB_LENGTH = me_pkg::TB_LENGTH,
  parameter int SW_LENGTH = me_pkg::SW_LENGTH,
  parameter int ZERO_BIAS = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   sad_valid,
  input  logic [SAD_W-1:0]       sad,
  output logic                   busy,
  output logic                   done,
  output logic [SAD_W-1:0]       min_sad,
  output logic signed [MV_W-1:0] mv_x,
  output logic signed [MV_W-1:0] mv_y
);

  localparam int N_CAND = SW_LENGTH - TB_LENGTH + 1;
  localparam int CTR    = (N_CAND - 1) / 2;
  localparam int POS_W  = $clog2(N_CAND);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(N_CAND - 1);

  if ((ZERO_BIAS < 0) || (ZERO_BIAS > 16383)) begin : g_bad_bias
    $error("ZERO_BIAS must fit in the SAD width");
  end

  logic [1:0]       state_r;
  logic [1:0]       state_nxt_s;
  logic [POS_W-1:0] pos_x_r;
  logic [POS_W-1:0] pos_y_r;
  logic             busy_r;
  logic             done_r;
  logic [SAD_W-1:0] min_sad_r;
  logic [MV_W-1:0]  mv_x_r;
  logic [MV_W-1:0]  mv_y_r;

  logic             start_search_s;
  logic             step_s;
  logic             last_cand_s;
  logic [SAD_W-1:0] best_sad_s;
  logic [POS_W-1:0] best_x_s;
  logic [POS_W-1:0] best_y_s;
  logic [SAD_W-1:0] nxt_best_sad_s;
  logic [POS_W-1:0] nxt_best_x_s;
  logic [POS_W-1:0] nxt_best_y_s;

  assign start_search_s = (state_r == ST_IDLE) && start;
  assign step_s         = (state_r == ST_SEARCH) && sad_valid;
  assign last_cand_s    = step_s && (pos_x_r == POS_LAST) && (pos_y_r == POS_LAST);

  // FSM next state
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nxt_s = ST_SEARCH;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SEARCH: begin
        if (last_cand_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_SEARCH;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM, raster counters and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      pos_x_r   <= {POS_W{1'b0}};
      pos_y_r   <= {POS_W{1'b0}};
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      min_sad_r <= {SAD_W{1'b0}};
      mv_x_r    <= {MV_W{1'b0}};
      mv_y_r    <= {MV_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s != ST_IDLE);
      done_r  <= last_cand_s;
      if (start_search_s) begin
        pos_x_r <= {POS_W{1'b0}};
        pos_y_r <= {POS_W{1'b0}};
      end else if (step_s) begin
        if (pos_x_r == POS_LAST) begin
          pos_x_r <= {POS_W{1'b0}};
          pos_y_r <= pos_y_r + {{(POS_W-1){1'b0}}, 1'b1};
        end else begin
          pos_x_r <= pos_x_r + {{(POS_W-1){1'b0}}, 1'b1};
          pos_y_r <= pos_y_r;
        end
      end else begin
        pos_x_r <= pos_x_r;
        pos_y_r <= pos_y_r;
      end
      // result includes the final candidate's own compare outcome
      if (last_cand_s) begin
        min_sad_r <= nxt_best_sad_s;
        mv_x_r    <= MV_W'(nxt_best_x_s) - MV_W'(CTR);
        mv_y_r    <= MV_W'(nxt_best_y_s) - MV_W'(CTR);
      end else begin
        min_sad_r <= min_sad_r;
        mv_x_r    <= mv_x_r;
        mv_y_r    <= mv_y_r;
      end
    end
  end

  sad_cmp #(
    .POS_W     (POS_W),
    .CTR       (CTR)
`ifdef ME_ZERO_BIAS_EN
    ,
    .ZERO_BIAS (ZERO_BIAS)
`endif
  ) u_sad_cmp (
    .clk          (clk),
    .rst_n        (rst_n),
    .init         (start_search_s),
    .en           (step_s),
    .sad          (sad),
    .pos_x        (pos_x_r),
    .pos_y        (pos_y_r),
    .best_sad     (best_sad_s),
    .best_x       (best_x_s),
    .best_y       (best_y_s),
    .nxt_best_sad (nxt_best_sad_s),
    .nxt_best_x   (nxt_best_x_s),
    .nxt_best_y   (nxt_best_y_s)
  );

  assign busy    = busy_r;
  assign done    = done_r;
  assign min_sad = min_sad_r;
  assign mv_x    = mv_x_r;
  assign mv_y    = mv_y_r;

endmodule
